if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Fetch stage of the RV32I pipeline: owns PCF, issues single-outstanding instruction-memory requests, and captures each returned instruction into the IF/ID register.
- Drives InstrD; InstrD[6:0] is the opcode consumed by the main decoder in ID.
- Honours hazard-unit StallD/FlushD and the EX-stage branch/jump redirect (PCSrcE/PCTargetE).

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), InstrD value when IF/ID is empty or flushed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address (= PCF).
- imem_rsp_valid  in  1  response valid, one per accepted request.
- imem_rdata  in  32  returned instruction.
- StallD  in  1  hold IF/ID contents.
- FlushD  in  1  invalidate IF/ID.
- PCSrcE  in  1  redirect fetch.
- PCTargetE  in  32  redirect target.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  IF/ID holds a real instruction.

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - PCF=RESET_PC; state=S_ISSUE.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req_valid=0 during the reset cycle.
  - imem is reset by the same reset; no response to a pre-reset request is delivered.
- Request output: imem_req_valid = (state==S_ISSUE) && !PCSrcE && !reset; imem_addr=PCF.
- Accept: the handshake completes when imem_req_valid && imem_req_ready.
- FSM:
  - S_ISSUE:
    - On accept: req_pc<=PCF, PCF<=PCF+4, go to S_WAIT.
    - Otherwise stay.
  - S_WAIT (one request outstanding):
    - On imem_rsp_valid with !StallD: load IF/ID, go to S_ISSUE.
    - On imem_rsp_valid with StallD: buf<=imem_rdata, go to S_HOLD.
  - S_HOLD: when !StallD, load IF/ID from buf, go to S_ISSUE.
  - S_DROP: on imem_rsp_valid, discard the data and go to S_ISSUE.
- IF/ID load: InstrD<=instr, PCD<=req_pc, PCPlus4D<=req_pc+4, ValidD<=1.
- Redirect (PCSrcE=1): PCF<=PCTargetE with bits [1:0] forced to 00. Then, by state:
  - S_ISSUE: the request is suppressed that cycle; state stays S_ISSUE.
  - S_WAIT without rsp_valid: go to S_DROP.
  - S_WAIT with rsp_valid the same cycle: the response is discarded and the state goes to S_ISSUE.
  - S_HOLD: buf is discarded; state goes to S_ISSUE.
  - S_DROP: state stays S_DROP.
- Redirect has priority over accept and over IF/ID load.
- IF/ID priority: FlushD > StallD > load.
  - FlushD: InstrD<=NOP_INSTR, ValidD<=0; PCD and PCPlus4D are don't-care.
  - StallD: hold all IF/ID outputs.
  - If there is no load and no stall, ValidD<=0 and InstrD<=NOP_INSTR (bubble).
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Latency and throughput:
  - Response at cycle t gives ValidD=1 at t+1.
  - The next request issues at t+1.
  - Peak rate is one instruction per (memory latency + 1) cycles.
- imem_addr may change while imem_req_valid is low. imem_addr never changes while a request is valid and not yet accepted, except when PCSrcE drops valid.

Decomposition:
- config.vh additions: `NOP_INSTR, `RESET_PC default, and the state encodings S_ISSUE/S_WAIT/S_HOLD/S_DROP (2-bit).
- One sub-module: if_id_reg, a parameterless IF/ID register with en (=~StallD), clr (=FlushD), load, and bubble inputs, holding InstrD/PCD/PCPlus4D/ValidD.

Test Plan:
- Reset, then imem with ready=1 and 1-cycle latency returning mem[a]=a|0x13:
  - imem_addr sequence 0, 4, 8.
  - InstrD 0x13, 0x17, 0x1B with PCD 0, 4, 8 and ValidD pulsing every 2nd cycle.
- StallD=1 for 3 cycles across a response at addr 0x10:
  - IF/ID holds the previous instruction; state goes to S_HOLD and no new request is issued.
  - On release, InstrD=mem[0x10], PCD=0x10.
- PCSrcE=1, PCTargetE=0x102 while in S_WAIT:
  - The in-flight response is discarded and ValidD stays 0.
  - The next imem_addr is 0x100.
- PCSrcE in the same cycle as imem_rsp_valid: no IF/ID load; the next request goes to the target.
- FlushD and StallD asserted together: InstrD=0x00000013, ValidD=0.
- imem_req_ready=0 for 4 cycles: imem_addr is stable at PCF and imem_req_valid stays high; PCF increments only on accept.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants and FSM encoding for the RV32I fetch stage.
// Default reset PC, the canonical NOP, and the 2-bit fetch-state enum.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id.sv
// IF/ID pipeline register: clear beats hold (en low), hold beats load, else bubble.
// One-cycle latency from load to outputs; no backpressure of its own, en_i freezes contents.
module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] nop_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clr_i) begin
            // PC fields are left alone on a flush; nothing downstream reads them when invalid
            instr_d = nop_i;
            valid_d = 1'b0;
        end else if (en_i) begin
            if (load_i) begin
                instr_d = instr_i;
                pc_d    = pc_i;
                pc4_d   = pc_i + 32'd4;
                valid_d = 1'b1;
            end else if (bubble_i) begin
                instr_d = nop_i;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= nop_i;
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns PCF, single outstanding imem request, fills IF/ID one cycle after the response.
// Stall parks a returned word in a holding buffer and blocks new requests; redirect drops in-flight data.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pcf_q, pcf_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  load_instr;
    logic         req_vld;
    logic         accept;
    logic         load;

    assign req_vld        = (state_q == S_ISSUE) && !PCSrcE && !reset;
    assign accept         = req_vld && imem_req_ready;
    assign imem_req_valid = req_vld;
    assign imem_addr      = pcf_q;

    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        req_pc_d   = req_pc_q;
        buf_d      = buf_q;
        load       = 1'b0;
        load_instr = imem_rdata;
        if (PCSrcE) begin
            // Redirect wins over accept and load; whatever is in flight or buffered is stale
            pcf_d = PCTargetE & 32'hFFFF_FFFC;
            case (state_q)
                S_WAIT:  state_d = imem_rsp_valid ? S_ISSUE : S_DROP;
                S_HOLD:  state_d = S_ISSUE;
                default: state_d = state_q;
            endcase
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (accept) begin
                        req_pc_d = pcf_q;
                        pcf_d    = pcf_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!StallD) begin
                            load    = 1'b1;
                            state_d = S_ISSUE;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        load       = 1'b1;
                        load_instr = buf_q;
                        state_d    = S_ISSUE;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) state_d = S_ISSUE;
                end
                default: state_d = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_ISSUE;
            pcf_q    <= RESET_PC;
            req_pc_q <= 32'd0;
            buf_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            req_pc_q <= req_pc_d;
            buf_q    <= buf_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .en_i       (~StallD),
        .clr_i      (FlushD),
        .load_i     (load),
        .bubble_i   (~load),
        .nop_i      (NOP_INSTR),
        .instr_i    (load_instr),
        .pc_i       (req_pc_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, then random stall/ready/latency against a program-order scoreboard.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD)
    );

    int n_chk = 0;
    int n_err = 0;

    // memory knobs
    int lat_knob  = 1;
    int lat_max   = 0;
    int rdy_pct   = 100;
    bit hash_mode = 1'b0;

    // scoreboard: program-order stream of instructions that ID should consume
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t        sbq[$];
    bit          sb_en = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    int          n_consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return hash_mode ? ((a * 32'h9E37_79B1) ^ 32'h13) : (a | 32'h13);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Instruction memory: one response per accepted request after 1..N cycles
    initial begin
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt  = 0;
        paddr = 32'd0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rdata     = mem_word(paddr);
                    pend           = 1'b0;
                end
            end
            imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (reset) begin
                pend = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("single_outstanding", {31'b0, pend}, 32'd0);
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = (lat_max > 0) ? $urandom_range(1, lat_max) : lat_knob;
                if (sb_en) begin
                    chk("sb_req_addr", imem_addr, exp_pc);
                    sbq.push_back('{exp_pc, mem_word(exp_pc)});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    // Monitor: ID consumes IF/ID when valid and neither stalled nor flushed
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (sb_en && !reset && ValidD && !StallD && !FlushD) begin
                n_consumed++;
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_underflow: consumed PCD=%h with nothing expected", PCD);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("sb_pcd", PCD, e.pc);
                    chk("sb_instr", InstrD, e.ins);
                    chk("sb_pcplus4", PCPlus4D, e.pc + 32'd4);
                end
            end
        end
    end

    task automatic dstep(input int idx, input logic st, input logic fl, input logic ps,
                         input logic [31:0] tg, input int lat, input int rdy,
                         input logic ereq, input logic [31:0] eaddr, input logic evd,
                         input logic [31:0] ei, input logic [31:0] epcd);
        string nm;
        @(negedge clk);
        reset = 1'b0;
        StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg;
        lat_knob = lat; rdy_pct = rdy;
        #4;
        nm = $sformatf("c%0d", idx);
        chk({nm, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, ereq});
        chk({nm, ".addr"}, imem_addr, eaddr);
        chk({nm, ".ValidD"}, {31'b0, ValidD}, {31'b0, evd});
        chk({nm, ".InstrD"}, InstrD, evd ? ei : 32'h13);
        if (evd) begin
            chk({nm, ".PCD"}, PCD, epcd);
            chk({nm, ".PCPlus4D"}, PCPlus4D, epcd + 32'd4);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
        @(negedge clk);
        #4;
        chk("rst.req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("rst.ValidD", {31'b0, ValidD}, 32'd0);
        chk("rst.InstrD", InstrD, 32'h13);
        chk("rst.PCD", PCD, 32'd0);
        chk("rst.PCPlus4D", PCPlus4D, 32'd0);

        //     idx st fl ps target        lat rdy  req addr          vd instr         pcd
        dstep( 0, 0, 0, 0, 32'h0,          1, 100, 1, 32'h0,         0, 32'h0,        32'h0);
        dstep( 1, 0, 0, 0, 32'h0,          1, 100, 0, 32'h4,         0, 32'h0,        32'h0);
        dstep( 2, 0, 0, 0, 32'h0,          1, 100, 1, 32'h4,         1, 32'h13,       32'h0);
        dstep( 3, 0, 0, 0, 32'h0,          1, 100, 0, 32'h8,         0, 32'h0,        32'h0);
        dstep( 4, 0, 0, 0, 32'h0,          1, 100, 1, 32'h8,         1, 32'h17,       32'h4);
        dstep( 5, 0, 0, 0, 32'h0,          1, 100, 0, 32'hC,         0, 32'h0,        32'h0);
        dstep( 6, 0, 0, 0, 32'h0,          1, 100, 1, 32'hC,         1, 32'h1B,       32'h8);
        dstep( 7, 0, 0, 0, 32'h0,          1, 100, 0, 32'h10,        0, 32'h0,        32'h0);
        dstep( 8, 1, 0, 0, 32'h0,          1, 100, 1, 32'h10,        1, 32'h1F,       32'hC);
        dstep( 9, 1, 0, 0, 32'h0,          1, 100, 0, 32'h14,        1, 32'h1F,       32'hC);
        dstep(10, 1, 0, 0, 32'h0,          1, 100, 0, 32'h14,        1, 32'h1F,       32'hC);
        dstep(11, 0, 0, 0, 32'h0,          1, 100, 0, 32'h14,        1, 32'h1F,       32'hC);
        dstep(12, 0, 0, 0, 32'h0,          2, 100, 1, 32'h14,        1, 32'h13,       32'h10);
        dstep(13, 0, 0, 1, 32'h102,        2, 100, 0, 32'h18,        0, 32'h0,        32'h0);
        dstep(14, 0, 0, 0, 32'h0,          2, 100, 0, 32'h100,       0, 32'h0,        32'h0);
        dstep(15, 0, 0, 0, 32'h0,          1, 100, 1, 32'h100,       0, 32'h0,        32'h0);
        dstep(16, 0, 0, 1, 32'hFFFF_FFF8,  1, 100, 0, 32'h104,       0, 32'h0,        32'h0);
        dstep(17, 0, 0, 0, 32'h0,          1, 100, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0);
        dstep(18, 0, 0, 0, 32'h0,          1, 100, 0, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
        dstep(19, 0, 0, 0, 32'h0,          1, 100, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFB, 32'hFFFF_FFF8);
        dstep(20, 0, 0, 0, 32'h0,          1, 100, 0, 32'h0,         0, 32'h0,        32'h0);
        dstep(21, 1, 1, 0, 32'h0,          1, 100, 1, 32'h0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        dstep(22, 0, 0, 0, 32'h0,          1, 100, 0, 32'h4,         0, 32'h0,        32'h0);
        dstep(23, 0, 0, 0, 32'h0,          1,   0, 1, 32'h4,         1, 32'h13,       32'h0);
        dstep(24, 0, 0, 0, 32'h0,          1,   0, 1, 32'h4,         0, 32'h0,        32'h0);
        dstep(25, 0, 0, 0, 32'h0,          1,   0, 1, 32'h4,         0, 32'h0,        32'h0);
        dstep(26, 0, 0, 0, 32'h0,          1,   0, 1, 32'h4,         0, 32'h0,        32'h0);
        dstep(27, 0, 0, 0, 32'h0,          1, 100, 1, 32'h4,         0, 32'h0,        32'h0);
        dstep(28, 0, 0, 0, 32'h0,          1, 100, 0, 32'h8,         0, 32'h0,        32'h0);
        dstep(29, 0, 0, 0, 32'h0,          1, 100, 1, 32'h8,         1, 32'h17,       32'h4);

        // Random phase: fresh reset, redirect to a misaligned address near the top of memory
        @(negedge clk);
        reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        hash_mode = 1'b1; lat_max = 3; rdy_pct = 100;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF1;
        @(negedge clk);
        PCSrcE = 1'b0; exp_pc = 32'hFFFF_FFF0; sb_en = 1'b1; rdy_pct = 70;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            StallD = ($urandom_range(0, 99) < 30);
        end
        @(negedge clk);
        StallD = 1'b0; rdy_pct = 0;
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("sb_drained", sbq.size(), 32'd0);
        chk("sb_activity", {31'b0, (n_consumed > 50)}, 32'd1);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
